// File: rtl/arb_periferico.sv
// Round-robin arbiter sharing one four-phase send/ack peripheral channel
// between two masters, with an optional abort when the peripheral never acks.
module arb_periferico #(
   parameter int DADOS_W = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                   arb_clock,
   input  logic                   arb_reset,
   input  logic [1:0]             req_send,
   input  logic [2*DADOS_W-1:0]   req_dados,
   output logic [1:0]             req_ack,
   output logic                   per_send,
   output logic [DADOS_W-1:0]     per_dados,
   input  logic                   per_ack,
   output logic [1:0]             arb_grant,
   output logic                   arb_erro
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FWD     = 2'd1;
   localparam logic [1:0] HOLD    = 2'd2;
   localparam logic [1:0] RELEASE = 2'd3;

   localparam logic       TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

   logic [1:0]         state_q, state_d;
   logic               last_q, last_d;
   logic [1:0]         grant_q, grant_d;
   logic [1:0]         reqAck_q, reqAck_d;
   logic               perSend_q, perSend_d;
   logic [DADOS_W-1:0] perDados_q, perDados_d;
   logic               erro_q, erro_d;
   logic [7:0]         cnt_q, cnt_d;

   logic               gIdx;
   logic               pickIdx;

   assign gIdx = grant_q[1];

   // On a tie the master that was not served last wins; otherwise the lone requester.
   always_comb begin
      pickIdx = req_send[1];
      if (req_send == 2'b11) begin
         pickIdx = ~last_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      reqAck_d   = reqAck_q;
      perSend_d  = perSend_q;
      perDados_d = perDados_q;
      erro_d     = 1'b0;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (|req_send) begin
               perDados_d = pickIdx ? req_dados[2*DADOS_W-1:DADOS_W]
                                    : req_dados[DADOS_W-1:0];
               grant_d    = pickIdx ? 2'b10 : 2'b01;
               perSend_d  = 1'b1;
               cnt_d      = 8'd0;
               state_d    = FWD;
            end
         end
         FWD: begin
            if (per_ack) begin
               reqAck_d = grant_q;
               state_d  = HOLD;
            end else if (TO_EN && (cnt_q == TO_LAST)) begin
               // Abort: the master never sees an ack and must be re-arbitrated.
               perSend_d = 1'b0;
               erro_d    = 1'b1;
               last_d    = gIdx;
               state_d   = RELEASE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         HOLD: begin
            if ((req_send & grant_q) == 2'b00) begin
               perSend_d = 1'b0;
               state_d   = RELEASE;
            end
         end
         RELEASE: begin
            if (!per_ack) begin
               reqAck_d = 2'b00;
               grant_d  = 2'b00;
               last_d   = gIdx;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge arb_clock or negedge arb_reset) begin
      if (!arb_reset) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         grant_q    <= 2'b00;
         reqAck_q   <= 2'b00;
         perSend_q  <= 1'b0;
         perDados_q <= '0;
         erro_q     <= 1'b0;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         reqAck_q   <= reqAck_d;
         perSend_q  <= perSend_d;
         perDados_q <= perDados_d;
         erro_q     <= erro_d;
         cnt_q      <= cnt_d;
      end
   end

   assign req_ack   = reqAck_q;
   assign per_send  = perSend_q;
   assign per_dados = perDados_q;
   assign arb_grant = grant_q;
   assign arb_erro  = erro_q;

endmodule

// File: tb/tb_arb_periferico.sv
// Directed testbench for arb_periferico: handshake relay, round-robin order,
// timeout abort, asynchronous reset and data latching.
module tb_arb_periferico;

   logic       clock;
   logic       arbReset;
   logic [1:0] reqSend;
   logic [7:0] reqDados;
   logic [1:0] reqAck;
   logic       perSend;
   logic [3:0] perDados;
   logic       perAck;
   logic [1:0] arbGrant;
   logic       arbErro;

   int errors = 0;
   int checks = 0;

   arb_periferico #(.DADOS_W(4), .TIMEOUT(16)) dut (
      .arb_clock (clock),
      .arb_reset (arbReset),
      .req_send  (reqSend),
      .req_dados (reqDados),
      .req_ack   (reqAck),
      .per_send  (perSend),
      .per_dados (perDados),
      .per_ack   (perAck),
      .arb_grant (arbGrant),
      .arb_erro  (arbErro)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Advance one rising edge and settle just after it, so outputs are sampled
   // away from the edge and new inputs are set up well before the next one.
   task automatic clockEdge();
      @(posedge clock);
      #1;
   endtask

   // Drive both masters' send bits and data.
   task automatic applyStimulus(input logic [1:0] send, input logic [3:0] d0, input logic [3:0] d1);
      reqSend  = send;
      reqDados = {d1, d0};
   endtask

   // One comparison: counts it, and on mismatch counts and reports the failure.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Zero-wait peripheral completing the transfer owned by master g (one-hot);
   // that master drops its send once acked.
   task automatic serve(input string tag, input logic [1:0] g);
      perAck = 1'b1;
      clockEdge();
      checkOutput({tag, " ack relayed"}, {6'd0, reqAck}, {6'd0, g});
      checkOutput({tag, " send held"}, {7'd0, perSend}, 8'd1);
      reqSend = reqSend & ~g;
      clockEdge();
      checkOutput({tag, " send released"}, {7'd0, perSend}, 8'd0);
      checkOutput({tag, " ack held"}, {6'd0, reqAck}, {6'd0, g});
      perAck = 1'b0;
      clockEdge();
      checkOutput({tag, " ack released"}, {6'd0, reqAck}, 8'd0);
      checkOutput({tag, " grant released"}, {6'd0, arbGrant}, 8'd0);
   endtask

   initial begin
      logic [1:0] expGrant;
      $display("[TB] start");
      arbReset = 1'b0;
      perAck   = 1'b0;
      applyStimulus(2'b00, 4'h0, 4'h0);
      #2;
      checkOutput("reset per_send", {7'd0, perSend}, 8'd0);
      checkOutput("reset per_dados", {4'd0, perDados}, 8'd0);
      checkOutput("reset req_ack", {6'd0, reqAck}, 8'd0);
      checkOutput("reset grant", {6'd0, arbGrant}, 8'd0);
      checkOutput("reset erro", {7'd0, arbErro}, 8'd0);
      clockEdge();
      arbReset = 1'b1;
      clockEdge();

      // Single master, peripheral acks two cycles after send.
      applyStimulus(2'b01, 4'hA, 4'h0);
      clockEdge();
      checkOutput("single grant", {6'd0, arbGrant}, 8'h01);
      checkOutput("single per_send", {7'd0, perSend}, 8'd1);
      checkOutput("single per_dados", {4'd0, perDados}, 8'h0A);
      checkOutput("single early ack", {6'd0, reqAck}, 8'd0);
      clockEdge();
      checkOutput("single wait ack", {6'd0, reqAck}, 8'd0);
      serve("single", 2'b01);
      checkOutput("single data held", {4'd0, perDados}, 8'h0A);

      // Fresh reset so master 0 wins the first tie.
      arbReset = 1'b0;
      clockEdge();
      arbReset = 1'b1;
      applyStimulus(2'b11, 4'h3, 4'hC);
      clockEdge();
      checkOutput("tie first grant", {6'd0, arbGrant}, 8'h01);
      checkOutput("tie first data", {4'd0, perDados}, 8'h03);
      serve("tie m0", 2'b01);
      clockEdge();
      checkOutput("tie second grant", {6'd0, arbGrant}, 8'h02);
      checkOutput("tie second data", {4'd0, perDados}, 8'h0C);
      serve("tie m1", 2'b10);

      // Continuous contention: ownership must alternate starting with master 0.
      for (int i = 0; i < 6; i++) begin
         expGrant = (i % 2 == 0) ? 2'b01 : 2'b10;
         applyStimulus(2'b11, 4'h1, 4'h2);
         clockEdge();
         checkOutput($sformatf("contention grant %0d", i), {6'd0, arbGrant}, {6'd0, expGrant});
         serve($sformatf("contention %0d", i), expGrant);
      end

      // Timeout: master 0 owns the channel, peripheral stays silent.
      applyStimulus(2'b11, 4'h7, 4'h9);
      clockEdge();
      checkOutput("timeout grant", {6'd0, arbGrant}, 8'h01);
      for (int i = 1; i < 16; i++) begin
         clockEdge();
         checkOutput($sformatf("timeout send cycle %0d", i), {7'd0, perSend}, 8'd1);
         checkOutput($sformatf("timeout no erro %0d", i), {7'd0, arbErro}, 8'd0);
      end
      clockEdge();
      checkOutput("timeout send dropped", {7'd0, perSend}, 8'd0);
      checkOutput("timeout erro pulse", {7'd0, arbErro}, 8'd1);
      checkOutput("timeout no ack", {6'd0, reqAck}, 8'd0);
      clockEdge();
      checkOutput("timeout erro single", {7'd0, arbErro}, 8'd0);
      checkOutput("timeout grant released", {6'd0, arbGrant}, 8'd0);
      clockEdge();
      checkOutput("after timeout grant m1", {6'd0, arbGrant}, 8'h02);
      checkOutput("after timeout data m1", {4'd0, perDados}, 8'h09);
      serve("after timeout m1", 2'b10);
      clockEdge();
      checkOutput("retry grant m0", {6'd0, arbGrant}, 8'h01);
      checkOutput("retry data m0", {4'd0, perDados}, 8'h07);
      serve("retry m0", 2'b01);

      // Data stability: changes after grant must not reach the peripheral.
      applyStimulus(2'b10, 4'h0, 4'h5);
      clockEdge();
      checkOutput("stable grant", {6'd0, arbGrant}, 8'h02);
      checkOutput("stable data latched", {4'd0, perDados}, 8'h05);
      applyStimulus(2'b10, 4'h0, 4'hF);
      clockEdge();
      checkOutput("stable data fwd", {4'd0, perDados}, 8'h05);
      serve("stable", 2'b10);
      checkOutput("stable data idle", {4'd0, perDados}, 8'h05);

      // Reset while in HOLD clears everything without waiting for a clock edge.
      applyStimulus(2'b01, 4'h6, 4'h8);
      clockEdge();
      perAck = 1'b1;
      clockEdge();
      checkOutput("pre-reset ack", {6'd0, reqAck}, 8'h01);
      arbReset = 1'b0;
      #1;
      checkOutput("midreset per_send", {7'd0, perSend}, 8'd0);
      checkOutput("midreset per_dados", {4'd0, perDados}, 8'd0);
      checkOutput("midreset req_ack", {6'd0, reqAck}, 8'd0);
      checkOutput("midreset grant", {6'd0, arbGrant}, 8'd0);
      perAck = 1'b0;
      applyStimulus(2'b11, 4'h6, 4'h8);
      clockEdge();
      arbReset = 1'b1;
      clockEdge();
      checkOutput("post-reset grant m0", {6'd0, arbGrant}, 8'h01);
      checkOutput("post-reset data m0", {4'd0, perDados}, 8'h06);
      serve("post-reset m0", 2'b01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/arb_periferico.md
# arb_periferico

Two-requester arbiter that shares the single 4-bit send/ack peripheral channel between two CPU-side masters. It sits between the CPUs and the PERIFERICO instance. Each CPU port speaks the same four-phase send/ack protocol as the peripheral. The block grants the channel round-robin, registers the granted master's data onto the peripheral bus, relays the handshake in both directions, and aborts a transfer the peripheral never acknowledges.

## Interface
Parameters:
- DADOS_W, 4, data width of every dados bus
- TIMEOUT, 16, cycles in FWD without per_ack before abort; 0 disables; legal range 0..255

Ports:
- arb_clock  in  1  single clock, all state on rising edge
- arb_reset  in  1  asynchronous, active-low reset
- req_send  in  2  send from master i (bit i)
- req_dados  in  2*DADOS_W  master i data in bits [i*DADOS_W +: DADOS_W]
- req_ack  out  2  ack to master i, registered
- per_send  out  1  send to peripheral, registered
- per_dados  out  DADOS_W  data to peripheral, registered
- per_ack  in  1  ack from peripheral
- arb_grant  out  2  one-hot current owner, 0 when idle, registered
- arb_erro  out  1  one-cycle pulse on timeout abort, registered

## Operation
- Four-phase protocol on both sides:
  - Master raises send with data stable.
  - Ack rises.
  - Master drops send.
  - Ack drops.
  - A master raises send again only after its ack is low.
- State `last` holds the index of the last master served or aborted. Reset value 1, so master 0 wins the first tie.
- States: IDLE, FWD, HOLD, RELEASE.
- IDLE: per_send=0, all req_ack=0, arb_grant=0.
  - If any req_send is high, pick g:
    - If only one is requesting, g is that master.
    - If both are requesting, g = ~last.
  - Latch per_dados <= req_dados[g], set arb_grant bit g, set per_send <= 1, clear timeout counter, go to FWD.
- FWD: per_send=1, counter increments each cycle.
  - If per_ack is high: req_ack[g] <= 1, go to HOLD.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: per_send <= 0, arb_erro <= 1 for one cycle, last <= g, go to RELEASE without asserting req_ack.
- HOLD: when req_send[g]==0, per_send <= 0, go to RELEASE.
- RELEASE: when per_ack==0, req_ack[g] <= 0, arb_grant <= 0, last <= g, go to IDLE.
- Data is latched once at grant; per_dados holds that value until the next grant. Changes on req_dados afterwards are ignored.
- The non-granted master's req_ack stays 0 throughout. Its request is only sampled in IDLE.
- An aborted master keeps send high and is re-arbitrated. The other master gets priority on the next tie.
- A master dropping send in FWD before ack is a protocol violation. The arbiter still completes the transaction.

## Timing
- Reset (arb_reset=0): state IDLE, last=1, counter=0. Outputs per_send=0, per_dados=0, req_ack=0, arb_grant=0, arb_erro=0, all immediately and asynchronously. This holds mid-transfer as well.
- Grant latency: req_send sampled high at edge k in IDLE → per_send, per_dados and arb_grant valid after edge k.
- Ack relay: per_ack sampled high at edge m → req_ack high after edge m.
- Send release: req_send[g] sampled low at edge n → per_send low after edge n.
- Ack release: per_ack sampled low at edge p → req_ack low and arb_grant=0 after edge p. IDLE lasts at least one cycle.
- Minimum transaction length: 4 cycles with a zero-wait peripheral.
- Timeout: per_send falls TIMEOUT cycles after it rose. arb_erro is high exactly one cycle.

## Test plan
- Single master:
  - Stimulus: master 0 sends 4'hA against a peripheral that acks in 2 cycles.
  - Response: per_dados=4'hA, full four-phase sequence on both sides, req_ack[1] stays 0, arb_grant returns to 0.
- Simultaneous requests after reset:
  - Stimulus: both masters send (4'h3 and 4'hC) at once.
  - Response: master 0 is served first with 4'h3, then master 1 with 4'hC, no overlap of req_ack bits.
- Continuous contention:
  - Stimulus: both masters re-request immediately, 6 transfers.
  - Response: grants alternate 0,1,0,1,0,1.
- Timeout:
  - Stimulus: TIMEOUT=16, peripheral never acks.
  - Response: per_send high exactly 16 cycles, one arb_erro pulse, req_ack stays 0, the other pending master is granted next.
- Reset mid-transfer:
  - Stimulus: assert arb_reset while in HOLD.
  - Response: all outputs 0 immediately. After release, with both masters requesting, master 0 is granted first.
- Data stability:
  - Stimulus: master 1 changes req_dados from 4'h5 to 4'hF after grant.
  - Response: per_dados stays 4'h5 until the next grant.
